// File: rtl/piso4_hs.sv
// Parallel-in serial-out converter: takes one NWORD-word block per handshake and emits it
// most-significant word first, one IWID-bit word per downstream handshake. The serial word port
// is named dout because "do" is a reserved word.
module piso4_hs #(
  parameter int IWID  = 12,
  parameter int NWORD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IWID*NWORD-1:0] di,
  input  logic                  di_valid,
  output logic                  di_ready,
  output logic [IWID-1:0]       dout,
  output logic                  do_valid,
  input  logic                  do_ready,
  output logic                  do_last
);

  localparam int BW = IWID * NWORD;
  localparam int CW = $clog2(NWORD);
  localparam logic [CW-1:0] CNT_LAST = CW'(NWORD - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]    state;
  logic [BW-1:0] sreg;
  logic [CW-1:0] cnt;

  logic          do_hs;
  logic          di_hs;

  assign do_valid = (state == ST_SHIFT);
  assign do_last  = do_valid & (cnt == CNT_LAST);
  assign dout     = sreg[BW-1 -: IWID];
  assign do_hs    = do_valid & do_ready;

  // A new block may enter while idle, or in the same cycle the final word of the current block leaves.
  assign di_ready = (state == ST_IDLE) | (do_hs & do_last);
  assign di_hs    = di_valid & di_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (di_hs) begin
      state <= ST_SHIFT;
      sreg  <= di;
      cnt   <= '0;
    end else if (do_hs) begin
      // Shifting on the final word too leaves the register all-zero, so dout reads 0 while idle.
      sreg <= {sreg[BW-IWID-1:0], {IWID{1'b0}}};
      if (do_last) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso4_hs.sv
// Scoreboard bench for piso4_hs: accepted blocks expand into an expected word queue that a
// negedge monitor drains, alongside a 6-deep SIPO window model for the round-trip check.
module tb_piso4_hs;

  localparam int IWID  = 12;
  localparam int NWORD = 4;
  localparam int BW    = IWID * NWORD;

  typedef struct {
    logic [IWID-1:0] data;
    logic            last;
  } word_t;

  logic            clk;
  logic            rst;
  logic [BW-1:0]   di;
  logic            di_valid;
  logic            di_ready;
  logic [IWID-1:0] dout;
  logic            do_valid;
  logic            do_ready;
  logic            do_last;

  int n_cmp;
  int n_err;
  int rdy_mode;
  bit mon_en;

  word_t         exp_q[$];
  logic [BW-1:0] blk_q[$];
  logic [IWID-1:0] sipo[6];

  piso4_hs #(.IWID(IWID), .NWORD(NWORD)) dut (
    .clk      (clk),
    .rst      (rst),
    .di       (di),
    .di_valid (di_valid),
    .di_ready (di_ready),
    .dout     (dout),
    .do_valid (do_valid),
    .do_ready (do_ready),
    .do_last  (do_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random stalls, 2 = driven by the test sequence.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      do_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 0) do_ready = 1'b1;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst && mon_en) begin
      bit exp_rdy;
      word_t w;
      exp_rdy = (exp_q.size() == 0) || (do_ready && exp_q.size() == 1);
      check("do_valid", {63'd0, do_valid}, {63'd0, exp_q.size() != 0});
      check("di_ready", {63'd0, di_ready}, {63'd0, exp_rdy});
      if (!do_valid) check("do_last_idle", {63'd0, do_last}, 64'd0);
      if (do_valid && do_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'd1, 64'd0);
        end else begin
          w = exp_q.pop_front();
          check("do", {52'd0, dout}, {52'd0, w.data});
          check("do_last", {63'd0, do_last}, {63'd0, w.last});
          for (int i = 5; i > 0; i--) sipo[i] = sipo[i-1];
          sipo[0] = dout;
          if (do_last) begin
            if (blk_q.size() == 0) check("round_trip_missing", 64'd1, 64'd0);
            else check("round_trip", {16'd0, sipo[3], sipo[2], sipo[1], sipo[0]},
                       {16'd0, blk_q.pop_front()});
          end
        end
      end
      if (di_valid && di_ready) begin
        for (int k = NWORD - 1; k >= 0; k--) begin
          w.data = di[IWID*k +: IWID];
          w.last = (k == 0);
          exp_q.push_back(w);
        end
        blk_q.push_back(di);
      end
    end
  end

  task automatic send_block(input logic [BW-1:0] b);
    bit acc;
    di       = b;
    di_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = di_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    di_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] r64;
    n_cmp    = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    rdy_mode = 2;
    rst      = 1'b0;
    di       = '0;
    di_valid = 1'b0;
    do_ready = 1'b0;
    for (int i = 0; i < 6; i++) sipo[i] = '0;

    #3;
    check("rst_do_valid", {63'd0, do_valid}, 64'd0);
    check("rst_do", {52'd0, dout}, 64'd0);
    check("rst_do_last", {63'd0, do_last}, 64'd0);
    check("rst_di_ready", {63'd0, di_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;
    rdy_mode = 0;
    idle_cycles(2);

    // Single block
    send_block({12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD});
    check("first_word_latency", {52'd0, dout}, 64'hAAA);
    idle_cycles(6);

    // Back-to-back blocks
    send_block({12'h001, 12'h002, 12'h003, 12'h004});
    send_block({12'h005, 12'h006, 12'h007, 12'h008});
    idle_cycles(8);

    // Backpressure while 0x222 is shown
    rdy_mode = 2;
    do_ready = 1'b1;
    send_block({12'h111, 12'h222, 12'h333, 12'h444});
    di_valid = 1'b0;
    @(posedge clk);
    #1;
    do_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_do", {52'd0, dout}, 64'h222);
      check("stall_valid", {63'd0, do_valid}, 64'd1);
      check("stall_di_ready", {63'd0, di_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    do_ready = 1'b1;
    rdy_mode = 0;
    idle_cycles(6);

    // Reset mid-block after two words have gone out
    send_block({12'h9A1, 12'h9A2, 12'h9A3, 12'h9A4});
    di_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check("arst_do_valid", {63'd0, do_valid}, 64'd0);
    check("arst_do", {52'd0, dout}, 64'd0);
    check("arst_do_last", {63'd0, do_last}, 64'd0);
    check("arst_di_ready", {63'd0, di_ready}, 64'd1);
    exp_q.delete();
    blk_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", {63'd0, do_valid}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Random blocks with random stalls and gaps
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      idle_cycles($urandom_range(0, 3));
      r64 = {$urandom(), $urandom()};
      send_block(r64[BW-1:0]);
    end
    di_valid = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_words", 64'(exp_q.size()), 64'd0);
    check("drain_blocks", 64'(blk_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
